uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: UART_TX_FIFO

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 10_000_000, meaning the system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the line rate; bit period TICKS = CLOCK_HZ/BAUD clocks, using integer division.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning the data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, with encoding 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning the stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, meaning the transmit FIFO entries; must be a power of 2 and at least 2.
REQ-007 SHALL have port Clock, input, 1 bit, the single system clock with rising-edge logic.
REQ-008 SHALL have port Reset, input, 1 bit, asynchronous, active-low reset.
REQ-009 SHALL have port Write_i, input, 1 bit, a one-clock request to push Data_i into the FIFO.
REQ-010 SHALL have port Data_i, input, DATA_BITS wide, the word to push.
REQ-011 SHALL have port Full_o, output, 1 bit, high while the FIFO holds FIFO_DEPTH words.
REQ-012 SHALL have port Count_o, output, $clog2(FIFO_DEPTH)+1 bits, the number of words currently in the FIFO.
REQ-013 SHALL have port Busy_o, output, 1 bit, high while a frame is on the line.
REQ-014 SHALL have port Done_o, output, 1 bit, a one-clock pulse at the end of each frame.
REQ-015 SHALL have port Tx_o, output, 1 bit, the registered serial line, which idles high.

Function
REQ-016 SHALL accept Write_i only when Full_o is low. A write while full is dropped with no state change, even if a pop occurs in the same cycle.
REQ-017 SHALL on a simultaneous accepted push and pop leave Count_o unchanged and keep FIFO order intact.
REQ-018 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-019 SHALL in IDLE with the FIFO non-empty pop the head word into the shift register and enter START on the same edge.
REQ-020 SHALL drive Tx_o low for START on the clock after the pop. A write to an empty idle block therefore produces Tx_o=0 two clocks after the write edge.
REQ-021 SHALL hold every bit (START, each DATA bit, PARITY, each STOP bit) for exactly TICKS clocks, timed by an internal counter that reloads at each bit boundary.
REQ-022 SHALL shift DATA out LSB first, DATA_BITS bits in total.
REQ-023 SHALL, when PARITY=1, send the XOR of the data bits; when PARITY=2, send its inverse; when PARITY=0, skip the PARITY state from DATA to STOP.
REQ-024 SHALL drive Tx_o high for STOP_BITS×TICKS clocks in STOP.
REQ-025 SHALL pulse Done_o for exactly one clock on the last clock of the final stop bit.
REQ-026 SHALL, if the FIFO is non-empty at that final STOP clock, pop the next word and enter START on the next edge with no idle gap; otherwise it SHALL return to IDLE.
REQ-027 SHALL hold Busy_o high in every state except IDLE.
REQ-028 SHALL ignore Write_i for frame timing: writes during a frame only fill the FIFO and never disturb the bit in progress.
REQ-029 SHALL keep Count_o within 0..FIFO_DEPTH, with the read and write pointers wrapping modulo FIFO_DEPTH.

Reset
REQ-030 SHALL, on Reset low, immediately set FSM=IDLE, Tx_o=1, Busy_o=0, Done_o=0, Count_o=0, Full_o=0, pointers=0, bit counter=0 and tick counter=0.
REQ-031 SHALL, if reset is asserted mid-frame, abort the frame, return the line high at once and discard the FIFO contents.
REQ-032 SHALL start no frame until at least one Write_i is accepted after reset release.

Verification
REQ-033 SHALL be covered by this scenario: CLOCK_HZ=10_000_000, BAUD=1_000_000, defaults, write 0xA5 -> Tx_o shows 0,1,0,1,0,0,1,0,1,1, each for 10 clocks; one Done_o pulse; Busy_o high for 100 clocks.
REQ-034 SHALL be covered by this scenario: PARITY=1, DATA_BITS=7, STOP_BITS=2, write 0x03 -> parity bit 0; frame length 11 bits = 110 clocks.
REQ-035 SHALL be covered by this scenario: PARITY=2, write 0x01 -> parity bit 0; write 0x00 -> parity bit 1.
REQ-036 SHALL be covered by this scenario: FIFO_DEPTH=4, five writes in consecutive clocks with the line idle -> first word popped, 4 queued, Full_o=1, no write dropped; then 5 back-to-back frames with no idle high between the stop bit and the next start bit, followed by 5 Done_o pulses.
REQ-037 SHALL be covered by this scenario: fill FIFO to 4 while busy, then a 5th write -> dropped, Count_o stays 4; a write in the pop cycle when full -> dropped.
REQ-038 SHALL be covered by this scenario: Reset low during DATA bit 3 -> Tx_o=1, Busy_o=0 and Count_o=0 in the same cycle; no Done_o pulse; idle after release.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a small power-of-two transmit FIFO
//
// Purpose:
//   Words pushed with Write_i are queued in a FIFO. When the line is idle, or when
//   a frame is on its final stop clock, the head word is popped and serialised as
//   START, DATA (LSB first), optional PARITY and STOP bits. Each bit lasts
//   CLOCK_HZ/BAUD clocks.
//
// Ports:
//   Clock    - system clock, rising edge
//   Reset    - asynchronous, active-low reset
//   Write_i  - one-clock push request, ignored while Full_o is high
//   Data_i   - word to push (DATA_BITS wide)
//   Full_o   - FIFO holds FIFO_DEPTH words
//   Count_o  - number of words currently queued
//   Busy_o   - a frame is on the line
//   Done_o   - one-clock pulse on the last clock of the final stop bit
//   Tx_o     - registered serial line, idles high

module uart_tx_fifo #(
   parameter int CLOCK_HZ   = 10_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic                          Write_i,
   input  logic [DATA_BITS-1:0]          Data_i,
   output logic                          Full_o,
   output logic [$clog2(FIFO_DEPTH):0]   Count_o,
   output logic                          Busy_o,
   output logic                          Done_o,
   output logic                          Tx_o
);

   localparam int TICKS = CLOCK_HZ / BAUD;
   localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;

   state_t               state;
   logic [TW-1:0]        tick;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;

   logic                 push;
   logic                 pop;
   logic                 not_empty;
   logic                 tick_last;
   logic                 stop_last;
   logic                 line_bit;
   logic [DATA_BITS-1:0] head;

   assign Full_o    = (Count_o == CW'(FIFO_DEPTH));
   assign not_empty = (Count_o != '0);
   assign head      = mem[rd_ptr];
   assign tick_last = (tick == TW'(TICKS - 1));
   assign stop_last = (state == ST_STOP) && tick_last && (bit_cnt == 4'(STOP_BITS - 1));

   // A write while full is dropped even if a pop frees a slot on the same edge.
   assign push = Write_i && !Full_o;

   // The head word leaves the FIFO either from idle or on the final stop clock,
   // which is what makes consecutive frames abut with no idle-high gap.
   assign pop  = not_empty && ((state == ST_IDLE) || stop_last);

   // ------------------------------------------------------------------
   // FIFO storage and occupancy
   // ------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (push) begin
         mem[wr_ptr] <= Data_i;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         Count_o <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   Count_o <= Count_o + CW'(1);
            2'b01:   Count_o <= Count_o - CW'(1);
            default: Count_o <= Count_o;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Line value for the current state; registered into Tx_o so the line
   // trails the state by exactly one clock.
   // ------------------------------------------------------------------
   always_comb begin
      line_bit = 1'b1;
      case (state)
         ST_START:  line_bit = 1'b0;
         ST_DATA:   line_bit = shreg[0];
         ST_PARITY: line_bit = par_bit;
         default:   line_bit = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // Frame sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state   <= ST_IDLE;
         tick    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         Tx_o    <= 1'b1;
         Busy_o  <= 1'b0;
         Done_o  <= 1'b0;
      end else begin
         // Outputs derive from the state held during this clock, so Busy_o,
         // Done_o and Tx_o all line up with the bit actually on the wire.
         Tx_o   <= line_bit;
         Busy_o <= (state != ST_IDLE);
         Done_o <= stop_last;

         // Parity is fixed at load time; odd parity is the inverted even sum.
         if (pop) begin
            shreg   <= head;
            par_bit <= (^head) ^ (PARITY == 2);
         end

         case (state)
            ST_IDLE: begin
               tick    <= '0;
               bit_cnt <= '0;
               if (pop) begin
                  state <= ST_START;
               end
            end

            ST_START: begin
               if (tick_last) begin
                  tick    <= '0;
                  bit_cnt <= '0;
                  state   <= ST_DATA;
               end else begin
                  tick <= tick + TW'(1);
               end
            end

            ST_DATA: begin
               if (tick_last) begin
                  tick  <= '0;
                  shreg <= shreg >> 1;
                  if (bit_cnt == 4'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
                     state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  tick <= tick + TW'(1);
               end
            end

            ST_PARITY: begin
               if (tick_last) begin
                  tick    <= '0;
                  bit_cnt <= '0;
                  state   <= ST_STOP;
               end else begin
                  tick <= tick + TW'(1);
               end
            end

            ST_STOP: begin
               if (tick_last) begin
                  tick <= '0;
                  if (bit_cnt == 4'(STOP_BITS - 1)) begin
                     bit_cnt <= '0;
                     state   <= pop ? ST_START : ST_IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  tick <= tick + TW'(1);
               end
            end

            default: begin
               state   <= ST_IDLE;
               tick    <= '0;
               bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;

   localparam int TICKS = 10;
   localparam int DEPTH = 4;
   localparam int DB[3] = '{8, 7, 8};
   localparam int PB[3] = '{0, 1, 2};
   localparam int SB[3] = '{1, 2, 1};

   typedef struct {
      logic [8:0] data;
      int         start;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr[3];
   logic [7:0] din_a;
   logic [6:0] din_b;
   logic [7:0] din_c;
   logic       full[3];
   logic [2:0] cnt[3];
   logic       busy[3];
   logic       done[3];
   logic       tx[3];

   int cyc = 0;

   logic [8:0] pend_d[3][$];
   int         pend_t[3][$];
   int         ready_t[3];
   exp_t       exp_q[3][$];
   logic       wr_req[3];
   logic [8:0] wr_dat[3];

   bit   mon_on[3];
   int   mon_off[3];
   int   mon_err[3];
   exp_t mon_rec[3];

   int n_pass = 0;
   int n_total = 0;

   uart_tx_fifo #(.CLOCK_HZ(10_000_000), .BAUD(1_000_000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
      .Clock(clk), .Reset(rst_n), .Write_i(wr[0]), .Data_i(din_a),
      .Full_o(full[0]), .Count_o(cnt[0]), .Busy_o(busy[0]), .Done_o(done[0]), .Tx_o(tx[0]));

   uart_tx_fifo #(.CLOCK_HZ(10_000_000), .BAUD(1_000_000), .DATA_BITS(7),
                  .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
      .Clock(clk), .Reset(rst_n), .Write_i(wr[1]), .Data_i(din_b),
      .Full_o(full[1]), .Count_o(cnt[1]), .Busy_o(busy[1]), .Done_o(done[1]), .Tx_o(tx[1]));

   uart_tx_fifo #(.CLOCK_HZ(10_000_000), .BAUD(1_000_000), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
      .Clock(clk), .Reset(rst_n), .Write_i(wr[2]), .Data_i(din_c),
      .Full_o(full[2]), .Count_o(cnt[2]), .Busy_o(busy[2]), .Done_o(done[2]), .Tx_o(tx[2]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int flen(int i);
      return TICKS * (1 + DB[i] + ((PB[i] != 0) ? 1 : 0) + SB[i]);
   endfunction

   // Frame bit b: 0 = start, then data LSB first, then parity, then stop bits.
   function automatic logic exp_bit(int i, logic [8:0] d, int b);
      logic p;
      if (b == 0) return 1'b0;
      if (b <= DB[i]) return d[b-1];
      if (PB[i] != 0 && b == DB[i] + 1) begin
         p = 1'b0;
         for (int k = 0; k < DB[i]; k++) p = p ^ d[k];
         return (PB[i] == 2) ? ~p : p;
      end
      return 1'b1;
   endfunction

   task automatic chk(string name, int i, int act, int expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s dut%0d actual=%0d expected=%0d (cycle %0d)", name, i, act, expv, cyc);
   endtask

   // Drive the requested writes for the next edge, advance the reference model
   // for that edge, then check occupancy after it.
   task automatic step();
      int t = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         logic       acc;
         logic [8:0] d;
         int         dummy;
         d   = wr_dat[i] & 9'((1 << DB[i]) - 1);
         acc = wr_req[i] && (pend_d[i].size() < DEPTH);
         if (pend_d[i].size() > 0 && t >= ready_t[i] && pend_t[i][0] < t) begin
            exp_t e;
            e.data  = pend_d[i].pop_front();
            dummy   = pend_t[i].pop_front();
            e.start = t + 1;
            exp_q[i].push_back(e);
            ready_t[i] = t + flen(i);
         end
         if (acc) begin
            pend_d[i].push_back(d);
            pend_t[i].push_back(t);
         end
         wr[i] = wr_req[i];
         case (i)
            0: din_a = d[7:0];
            1: din_b = d[6:0];
            default: din_c = d[7:0];
         endcase
         wr_req[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) wr[i] = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("count", i, int'(cnt[i]), pend_d[i].size());
         chk("full", i, int'(full[i]), (pend_d[i].size() == DEPTH) ? 1 : 0);
      end
   endtask

   function automatic bit activity();
      for (int i = 0; i < 3; i++)
         if (pend_d[i].size() != 0 || exp_q[i].size() != 0 || mon_on[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain();
      int n = 0;
      while (activity() && n < 3000) begin
         step();
         n++;
      end
      chk("drain_timeout", 0, (n >= 3000) ? 1 : 0, 0);
      step();
      step();
   endtask

   task automatic mon_sample(int i);
      int   o;
      logic eb;
      logic ed;
      o  = mon_off[i];
      eb = exp_bit(i, mon_rec[i].data, o / TICKS);
      ed = (o == flen(i) - 1);
      if (tx[i] !== eb || busy[i] !== 1'b1 || done[i] !== ed) mon_err[i]++;
      mon_off[i]++;
      if (mon_off[i] == flen(i)) begin
         chk("frame_wave", i, mon_err[i], 0);
         mon_on[i] = 1'b0;
      end
   endtask

   // Monitor: a falling line starts a frame, which is matched against the head
   // of that DUT's expectation queue sample by sample.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            mon_on[i] = 1'b0;
         end else if (!mon_on[i]) begin
            if (tx[i] === 1'b0) begin
               chk("frame_expected", i, (exp_q[i].size() > 0) ? 1 : 0, 1);
               if (exp_q[i].size() > 0) begin
                  mon_rec[i] = exp_q[i].pop_front();
                  chk("start_cycle", i, cyc, mon_rec[i].start);
               end else begin
                  mon_rec[i].data  = '0;
                  mon_rec[i].start = cyc;
               end
               mon_on[i]  = 1'b1;
               mon_off[i] = 0;
               mon_err[i] = 0;
               mon_sample(i);
            end else begin
               chk("idle_busy_done", i, int'({busy[i], done[i]}), 0);
            end
         end else begin
            mon_sample(i);
         end
      end
   end

   initial begin
      int t0;
      int w;
      for (int i = 0; i < 3; i++) begin
         wr[i] = 1'b0;
         wr_req[i] = 1'b0;
         wr_dat[i] = '0;
         ready_t[i] = 0;
         mon_on[i] = 1'b0;
      end
      din_a = '0;
      din_b = '0;
      din_c = '0;
      rst_n = 1'b0;

      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_tx", i, int'(tx[i]), 1);
         chk("rst_busy", i, int'(busy[i]), 0);
         chk("rst_done", i, int'(done[i]), 0);
         chk("rst_count", i, int'(cnt[i]), 0);
         chk("rst_full", i, int'(full[i]), 0);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);

      repeat (5) step();

      // Single frames: 8N1 0xA5, 7E2 0x03 (parity 0), 8O1 0x01 (parity 0)
      wr_req[0] = 1'b1; wr_dat[0] = 9'h0A5;
      wr_req[1] = 1'b1; wr_dat[1] = 9'h003;
      wr_req[2] = 1'b1; wr_dat[2] = 9'h001;
      step();
      drain();

      // Odd parity of 0x00 is 1
      wr_req[2] = 1'b1; wr_dat[2] = 9'h000;
      wr_req[0] = 1'b1; wr_dat[0] = 9'h0FF;
      wr_req[1] = 1'b1; wr_dat[1] = 9'h07F;
      step();
      drain();

      // Burst of five from idle, a sixth write while full, then a write on the pop edge
      t0 = cyc + 1;
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 3; i++) begin
            wr_req[i] = 1'b1;
            wr_dat[i] = 9'($urandom);
         end
         step();
      end
      for (int i = 0; i < 3; i++) begin
         chk("burst_count", i, int'(cnt[i]), 4);
         chk("burst_full", i, int'(full[i]), 1);
      end
      for (int k = 0; k < 130; k++) begin
         for (int i = 0; i < 3; i++) begin
            if (cyc + 1 == t0 + 1 + flen(i)) begin
               wr_req[i] = 1'b1;
               wr_dat[i] = 9'($urandom);
            end
         end
         step();
      end
      drain();

      // Random traffic, dense enough to hit full and dropped writes
      repeat (3000) begin
         for (int i = 0; i < 3; i++) begin
            if ($urandom_range(29) == 0) begin
               wr_req[i] = 1'b1;
               wr_dat[i] = 9'($urandom);
            end
         end
         step();
      end
      drain();

      // Reset during data bit 3 of a frame with words still queued
      w = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         wr_req[i] = 1'b1;
         wr_dat[i] = 9'h05A;
      end
      step();
      for (int k = 0; k < 2; k++) begin
         wr_req[0] = 1'b1;
         wr_dat[0] = 9'($urandom);
         step();
      end
      while (cyc < w + 2 + 45) step();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("midrst_tx", i, int'(tx[i]), 1);
         chk("midrst_busy", i, int'(busy[i]), 0);
         chk("midrst_count", i, int'(cnt[i]), 0);
         chk("midrst_done", i, int'(done[i]), 0);
         pend_d[i].delete();
         pend_t[i].delete();
         exp_q[i].delete();
         ready_t[i] = 0;
      end
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      repeat (40) step();
      for (int i = 0; i < 3; i++) chk("post_rst_busy", i, int'(busy[i]), 0);

      // Normal operation after reset release
      for (int i = 0; i < 3; i++) begin
         wr_req[i] = 1'b1;
         wr_dat[i] = 9'($urandom);
      end
      step();
      drain();

      for (int i = 0; i < 3; i++) begin
         chk("leftover_expected", i, exp_q[i].size(), 0);
         chk("final_count", i, int'(cnt[i]), 0);
         chk("final_tx", i, int'(tx[i]), 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
